// File: rtl/zz_scan_buf_if.sv
// Coefficient input handshake and zigzag replay output of the scan buffer.
interface zz_scan_buf_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  coef_valid_i;
    logic [DATA_WIDTH-1:0] coef_data_i;
    logic                  coef_ready_o;
    logic                  zz_go_o;
    logic [DATA_WIDTH-1:0] zz_data_o;
    logic [5:0]            zz_len_o;
    logic                  zz_busy_o;

    // Upstream quantizer side plus the consumer of the replayed block
    modport master (
        output coef_valid_i,
        output coef_data_i,
        input  coef_ready_o,
        input  zz_go_o,
        input  zz_data_o,
        input  zz_len_o,
        input  zz_busy_o
    );

    // Buffer side
    modport slave (
        input  coef_valid_i,
        input  coef_data_i,
        output coef_ready_o,
        output zz_go_o,
        output zz_data_o,
        output zz_len_o,
        output zz_busy_o
    );
endinterface

// File: rtl/zz_scan_buf.sv
// Ping-pong 2x64 coefficient buffer: raster writes land at their zigzag
// address, each full bank is replayed in zigzag order with a start pulse
// and the zigzag index of its last nonzero AC coefficient.
module zz_scan_buf #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic         clk_x8_i,
    input  logic         rst_n_i,
    zz_scan_buf_if.slave bus_if
);

    localparam int unsigned IDX_W   = 6;
    localparam int unsigned ADDR_W  = IDX_W + 1;
    localparam int unsigned DEPTH   = 2 * 64;
    localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;
    localparam logic [IDX_W-1:0] GAP_LAST = 6'(GAP_CYCLES - 1);

    // Raster index -> zigzag position (standard JPEG order)
    localparam logic [IDX_W-1:0] ZZ_LUT [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GO     = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Write side state
    logic                  r_wr_bank;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [1:0]            r_full;
    logic [IDX_W-1:0]      r_last_nz [2];
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Read side state
    state_t                r_state;
    logic                  r_rd_bank;
    logic [IDX_W-1:0]      r_cnt;
    logic                  r_go;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_len;
    logic                  r_busy;

    logic                  w_ready;
    logic                  w_xfer;
    logic [IDX_W-1:0]      w_wr_zz;
    logic                  w_wr_done;
    logic                  w_release;
    logic [1:0]            w_full_nxt;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      w_cnt_nxt;
    logic                  w_go_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [IDX_W-1:0]      w_len_nxt;
    logic                  w_busy_nxt;

    assign w_ready   = ~r_full[r_wr_bank];
    assign w_xfer    = bus_if.coef_valid_i & w_ready;
    assign w_wr_zz   = ZZ_LUT[r_wr_idx];
    assign w_wr_done = w_xfer && (r_wr_idx == LAST_IDX);
    assign w_release = (r_state == S_STREAM) && (r_cnt == LAST_IDX);

    // Raster counter and write bank pointer
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_xfer) begin
            r_wr_idx <= r_wr_idx + 6'd1;
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Track highest zigzag index holding a nonzero AC coefficient per bank
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_nz[0] <= '0;
            r_last_nz[1] <= '0;
        end else if (w_xfer) begin
            if (r_wr_idx == '0) begin
                r_last_nz[r_wr_bank] <= '0;
            end else if ((bus_if.coef_data_i != '0) && (w_wr_zz > r_last_nz[r_wr_bank])) begin
                r_last_nz[r_wr_bank] <= w_wr_zz;
            end
        end
    end

    // Bank fill and release can coincide; they always target different banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Bank full flags
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Coefficient storage, written at the zigzag address; contents survive reset
    always_ff @(posedge clk_x8_i) begin
        if (w_xfer) begin
            r_mem[{r_wr_bank, w_wr_zz}] <= bus_if.coef_data_i;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next state; the counter restarts on every state change
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_full[r_rd_bank]) w_state_nxt = S_GO;
            S_GO:     w_state_nxt = S_STREAM;
            S_STREAM: if (r_cnt == LAST_IDX) w_state_nxt = S_GAP;
            S_GAP:    if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        w_cnt_nxt = (w_state_nxt != r_state) ? '0 : (r_cnt + 6'd1);
    end

    // Read FSM outputs, computed for the next cycle so they can be registered
    always_comb begin
        w_go_nxt   = 1'b0;
        w_data_nxt = '0;
        w_len_nxt  = r_len;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            S_GO: begin
                w_go_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
                w_len_nxt  = r_last_nz[r_rd_bank];
            end
            S_STREAM: begin
                w_busy_nxt = 1'b1;
                w_data_nxt = r_mem[ADDR_W'({r_rd_bank, w_cnt_nxt})];
            end
            S_GAP:   w_busy_nxt = 1'b1;
            default: w_busy_nxt = 1'b0;
        endcase
    end

    // Read counter and read bank pointer
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_go   <= 1'b0;
            r_data <= '0;
            r_len  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_go   <= w_go_nxt;
            r_data <= w_data_nxt;
            r_len  <= w_len_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign bus_if.coef_ready_o = w_ready;
    assign bus_if.zz_go_o      = r_go;
    assign bus_if.zz_data_o    = r_data;
    assign bus_if.zz_len_o     = r_len;
    assign bus_if.zz_busy_o    = r_busy;

endmodule
